// File: rtl/mips32_prog_loader_if.sv
// Stream-in and instruction-memory write signals of the MIPS32 program loader.
// master = stream source / memory sink side, slave = the loader itself.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
);
  // Handshake: a word transfers on a rising clk1 edge where s_valid and s_ready
  // are both 1; s_ready never depends combinationally on s_valid.
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Streams a program into instruction memory, pads it with HALT_WORD, then releases the CPU.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum of accepted words).
module mips32_prog_loader #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 load_start,
  mips32_prog_loader_if.slave  bus,
  output logic                 busy,
  output logic                 cpu_run,
  output logic [ADDR_W:0]      word_count,
  output logic                 overflow,
  output logic [31:0]          checksum,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The pointer is one bit wider than the address so it can reach DEPTH
  // ("everything scheduled") instead of wrapping back to 0.
  localparam logic [ADDR_W:0] PTR_END  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_overflow;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_start;
  logic              w_ready;
  logic              w_accept;
  logic              w_fill_wr;

  assign w_start   = load_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_ready   = (r_state == S_LOAD) && (r_ptr != PTR_END);
  assign w_accept  = w_ready && bus.s_valid;
  assign w_fill_wr = (r_state == S_FILL) && (r_ptr != PTR_END);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Writes are registered, so LOAD/FILL are held until the last write has been
  // presented; DONE therefore never overlaps an imem_we cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        if (r_ptr == PTR_END)
          w_next = S_DONE;
        else if (w_accept && bus.s_last && (r_ptr != PTR_LAST))
          w_next = S_FILL;
      end
      S_FILL: if (r_ptr == PTR_END) w_next = S_DONE;
      S_DONE: if (load_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_ptr        <= '0;
        r_word_count <= '0;
        r_overflow   <= 1'b0;
      end else if (w_accept) begin
        r_we         <= 1'b1;
        r_addr       <= r_ptr[ADDR_W-1:0];
        r_wdata      <= bus.s_data;
        r_ptr        <= r_ptr + 1'b1;
        r_word_count <= r_word_count + 1'b1;
        if (!bus.s_last && (r_ptr == PTR_LAST))
          r_overflow <= 1'b1;
      end else if (w_fill_wr) begin
        r_we    <= 1'b1;
        r_addr  <= r_ptr[ADDR_W-1:0];
        r_wdata <= HALT_WORD;
        r_ptr   <= r_ptr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)           r_checksum <= '0;
    else if (w_start)  r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum ^ bus.s_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign bus.s_ready    = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign busy           = (r_state == S_LOAD) || (r_state == S_FILL);
  assign cpu_run        = (r_state == S_DONE);
  assign word_count     = r_word_count;
  assign overflow       = r_overflow;
  assign dbg_state      = r_state;

endmodule
